// File: rtl/carfield_mbox_pkg.sv
// -----------------------------------------------------------------------------
// carfield_mbox_pkg
// Shared definitions for the Carfield mailbox unit: per-mailbox register byte
// offsets, slot stride, handshake FSM state encoding, the per-mailbox state
// record and a byte-strobe merge helper.
// -----------------------------------------------------------------------------
package carfield_mbox_pkg;

  // Each mailbox occupies one 0x40-byte slot inside the window.
  localparam int unsigned SlotStride = 'h40;
  localparam int unsigned SlotShift  = $clog2(SlotStride);

  // Register byte offsets inside a slot.
  localparam logic [5:0] OFF_LETTER0  = 6'h00;
  localparam logic [5:0] OFF_LETTER1  = 6'h04;
  localparam logic [5:0] OFF_DOORBELL = 6'h08;
  localparam logic [5:0] OFF_ACK      = 6'h0C;
  localparam logic [5:0] OFF_SND_CLR  = 6'h10;
  localparam logic [5:0] OFF_IRQ_EN   = 6'h14;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [31:0] letter0;
    logic [31:0] letter1;
    logic        rcv_pend;
    logic        snd_pend;
    logic        rcv_en;
    logic        snd_en;
  } mbox_state_t;

  // Replace only the bytes whose strobe bit is set.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/carfield_mailbox_unit_if.sv
// -----------------------------------------------------------------------------
// carfield_mailbox_unit_if
// Request/response register-bus bundle for the mailbox unit. Signal names keep
// the responder-side _i/_o suffixes so they read the same as the unit's pins.
//   slave  modport : the mailbox unit (accepts requests, returns responses)
//   master modport : the host side driving requests
// -----------------------------------------------------------------------------
interface carfield_mailbox_unit_if #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 32
) ();

  logic                   req_valid_i;
  logic                   req_ready_o;
  logic [AddrWidth-1:0]   req_addr_i;
  logic                   req_write_i;
  logic [DataWidth-1:0]   req_wdata_i;
  logic [DataWidth/8-1:0] req_wstrb_i;
  logic                   rsp_valid_o;
  logic                   rsp_ready_i;
  logic [DataWidth-1:0]   rsp_rdata_o;
  logic                   rsp_error_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_wstrb_i,
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_wstrb_i,
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o
  );

endinterface

// File: rtl/carfield_mbox_slot.sv
// -----------------------------------------------------------------------------
// carfield_mbox_slot
// Registers of one mailbox: two letter words, doorbell/ack pend bits, interrupt
// enables, and the registered doorbell/completion interrupt outputs.
//   clk_i, rst_i  clock, synchronous active-high reset
//   we_i          decoded, error-free write to this slot
//   reg_off_i     byte offset inside the slot
//   wdata_i       write data, wstrb_i byte strobes
//   state_o       current register contents (for the read mux)
//   irq_rcv_o     rcv_pend & rcv_en, irq_snd_o snd_pend & snd_en
// -----------------------------------------------------------------------------
module carfield_mbox_slot
  import carfield_mbox_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [5:0]  reg_off_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output mbox_state_t state_o,
  output logic        irq_rcv_o,
  output logic        irq_snd_o
);

  mbox_state_t state_q, state_d;
  logic        irq_rcv_q, irq_snd_q;
  logic        ctrl_hit;

  // Control registers only react to a set bit 0 in the low byte.
  assign ctrl_hit = wstrb_i[0] & wdata_i[0];

  always_comb begin
    // NOTE: default assigned first so every path drives state_d; no latch.
    state_d = state_q;
    if (we_i) begin
      case (reg_off_i)
        OFF_LETTER0:  state_d.letter0 = apply_wstrb(state_q.letter0, wdata_i, wstrb_i);
        OFF_LETTER1:  state_d.letter1 = apply_wstrb(state_q.letter1, wdata_i, wstrb_i);
        OFF_DOORBELL: if (ctrl_hit) state_d.rcv_pend = 1'b1;
        OFF_ACK: begin
          // An ack without a pending doorbell is silently ignored.
          if (ctrl_hit && state_q.rcv_pend) begin
            state_d.rcv_pend = 1'b0;
            state_d.snd_pend = 1'b1;
          end
        end
        OFF_SND_CLR:  if (ctrl_hit) state_d.snd_pend = 1'b0;
        OFF_IRQ_EN: begin
          if (wstrb_i[0]) begin
            state_d.rcv_en = wdata_i[0];
            state_d.snd_en = wdata_i[1];
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: letters live in flops, not a RAM, and are reset with everything
  // else so a post-reset read returns 0.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments for all state in clocked processes.
    if (rst_i) begin
      state_q   <= '0;
      irq_rcv_q <= 1'b0;
      irq_snd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      // Built from next state so the irq moves together with rsp_valid_o.
      irq_rcv_q <= state_d.rcv_pend & state_d.rcv_en;
      irq_snd_q <= state_d.snd_pend & state_d.snd_en;
    end
  end

  assign state_o   = state_q;
  assign irq_rcv_o = irq_rcv_q;
  assign irq_snd_o = irq_snd_q;

endmodule

// File: rtl/carfield_mailbox_unit.sv
// -----------------------------------------------------------------------------
// carfield_mailbox_unit
// Register-bus responder for the inter-domain mailbox window. Decodes host
// accesses, runs the single-outstanding IDLE/RESP handshake and hosts NumMbox
// mailbox slots.
//   clk_i, rst_i          clock, synchronous active-high reset
//   bus (slave modport)   req_* request channel, rsp_* response channel
//   irq_rcv_o[NumMbox]    per-mailbox doorbell interrupt (receiver side)
//   irq_snd_o[NumMbox]    per-mailbox completion interrupt (sender side)
// -----------------------------------------------------------------------------
module carfield_mailbox_unit
  import carfield_mbox_pkg::*;
#(
  parameter int          AddrWidth = 64,
  parameter int          DataWidth = 32,
  parameter int          NumMbox   = 4,
  parameter logic [63:0] MboxBase  = 64'h4000_0000,
  parameter logic [63:0] MboxSize  = 64'h0000_1000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  carfield_mailbox_unit_if.slave bus,
  output logic [NumMbox-1:0]     irq_rcv_o,
  output logic [NumMbox-1:0]     irq_snd_o
);

  state_e                state_q, state_d;
  logic [DataWidth-1:0]  rsp_rdata_q;
  logic                  rsp_error_q;

  logic [AddrWidth-1:0]  off;
  logic [3:0]            slot;
  logic [5:0]            reg_off;
  logic                  acc_err, accept;
  logic [DataWidth-1:0]  rd_data;
  mbox_state_t           slot_state [NumMbox];
  mbox_state_t           sel;

  // ---------------------------------------------------------------------------
  // Decode. An address below the base wraps to a huge offset, so one unsigned
  // compare covers both window edges. Slot and register come straight from the
  // offset bits.
  // ---------------------------------------------------------------------------
  assign off     = bus.req_addr_i - MboxBase[AddrWidth-1:0];
  assign slot    = off[SlotShift +: 4];
  assign reg_off = off[5:0];

  assign acc_err = (off >= MboxSize[AddrWidth-1:0])
                 | (int'(slot) >= NumMbox)
                 | (bus.req_addr_i[1:0] != 2'b00)
                 | (reg_off > OFF_IRQ_EN);

  assign accept = (state_q == ST_IDLE) & bus.req_valid_i;

  for (genvar i = 0; i < NumMbox; i++) begin : g_slot
    carfield_mbox_slot u_slot (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .we_i      (accept & ~acc_err & bus.req_write_i & (slot == 4'(i))),
      .reg_off_i (reg_off),
      .wdata_i   (bus.req_wdata_i),
      .wstrb_i   (bus.req_wstrb_i),
      .state_o   (slot_state[i]),
      .irq_rcv_o (irq_rcv_o[i]),
      .irq_snd_o (irq_snd_o[i])
    );
  end

  // Read mux; ACK and SND_CLR read back as 0.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NumMbox; i++) begin
      if (slot == 4'(i)) sel = slot_state[i];
    end
    rd_data = '0;
    case (reg_off)
      OFF_LETTER0:  rd_data = sel.letter0;
      OFF_LETTER1:  rd_data = sel.letter1;
      OFF_DOORBELL: rd_data[1:0] = {sel.snd_pend, sel.rcv_pend};
      OFF_IRQ_EN:   rd_data[1:0] = {sel.snd_en, sel.rcv_en};
      default:      ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    bus.req_ready_o = 1'b0;
    bus.rsp_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) state_d = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid_o = 1'b1;
        if (bus.rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response registers load only on accept, so they hold under backpressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else if (accept) begin
      rsp_rdata_q <= (acc_err | bus.req_write_i) ? '0 : rd_data;
      rsp_error_q <= acc_err;
    end
  end

  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_error_o = rsp_error_q;

endmodule

// File: tb/tb_carfield_mailbox_unit.sv
// -----------------------------------------------------------------------------
// tb_carfield_mailbox_unit
// Directed scenarios followed by randomized register traffic. A behavioural
// mailbox model (plain arrays) predicts every response and interrupt level; a
// negedge monitor compares the DUT against it every cycle, and a few literal
// expectations pin the model itself.
// -----------------------------------------------------------------------------
module tb_carfield_mailbox_unit;

  localparam int          NUM  = 4;
  localparam logic [63:0] BASE = 64'h4000_0000;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [NUM-1:0] irq_rcv, irq_snd;

  always #5 clk_i = ~clk_i;

  carfield_mailbox_unit_if #(.AddrWidth(64), .DataWidth(32)) bus ();

  carfield_mailbox_unit #(
    .AddrWidth(64), .DataWidth(32), .NumMbox(NUM),
    .MboxBase(BASE), .MboxSize(64'h1000)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bus       (bus),
    .irq_rcv_o (irq_rcv),
    .irq_snd_o (irq_snd)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural mailbox state
  logic [31:0] m_l0 [NUM];
  logic [31:0] m_l1 [NUM];
  bit          m_rp [NUM];
  bit          m_sp [NUM];
  bit          m_re [NUM];
  bit          m_se [NUM];

  // Expected outputs
  logic           exp_ready, exp_valid, exp_error;
  logic [31:0]    exp_rdata;
  logic [NUM-1:0] exp_irq_rcv, exp_irq_snd;
  bit             chk_en  = 0;
  bit             in_resp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) begin
      m_l0[i] = '0; m_l1[i] = '0;
      m_rp[i] = 0;  m_sp[i] = 0; m_re[i] = 0; m_se[i] = 0;
    end
    exp_ready = 1'b1; exp_valid = 1'b0; exp_error = 1'b0; exp_rdata = '0;
    exp_irq_rcv = '0; exp_irq_snd = '0;
  endtask

  function automatic void model_exec(input logic [63:0] a, input logic w,
                                     input logic [31:0] d, input logic [3:0] s,
                                     output logic [31:0] rd, output logic er);
    logic [63:0] off;
    int slot, regi;
    off  = a - BASE;
    slot = int'((off >> 6) & 64'hF);
    regi = int'((off >> 2) & 64'hF);
    er = (a < BASE) || (a >= BASE + 64'h1000) || (slot >= NUM) ||
         (a[1:0] != 2'b00) || (regi > 5);
    rd = '0;
    if (er) return;
    if (!w) begin
      case (regi)
        0: rd = m_l0[slot];
        1: rd = m_l1[slot];
        2: rd = {30'b0, m_sp[slot], m_rp[slot]};
        5: rd = {30'b0, m_se[slot], m_re[slot]};
        default: rd = '0;
      endcase
    end else begin
      case (regi)
        0: for (int b = 0; b < 4; b++) if (s[b]) m_l0[slot][8*b +: 8] = d[8*b +: 8];
        1: for (int b = 0; b < 4; b++) if (s[b]) m_l1[slot][8*b +: 8] = d[8*b +: 8];
        2: if (s[0] && d[0]) m_rp[slot] = 1;
        3: if (s[0] && d[0] && m_rp[slot]) begin m_rp[slot] = 0; m_sp[slot] = 1; end
        4: if (s[0] && d[0]) m_sp[slot] = 0;
        5: if (s[0]) begin m_re[slot] = d[0]; m_se[slot] = d[1]; end
        default: ;
      endcase
    end
  endfunction

  task automatic update_irq();
    for (int i = 0; i < NUM; i++) begin
      exp_irq_rcv[i] = m_rp[i] & m_re[i];
      exp_irq_snd[i] = m_sp[i] & m_se[i];
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("req_ready", 64'(bus.req_ready_o), 64'(exp_ready));
      check("rsp_valid", 64'(bus.rsp_valid_o), 64'(exp_valid));
      if (exp_valid) begin
        check("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(exp_rdata));
        check("rsp_error", 64'(bus.rsp_error_o), 64'(exp_error));
      end
      check("irq_rcv", 64'(irq_rcv), 64'(exp_irq_rcv));
      check("irq_snd", 64'(irq_snd), 64'(exp_irq_snd));
    end
  end

  // --------------------------------------------------------------------------
  // Bus driver tasks; all called at posedge+1 or negedge
  // --------------------------------------------------------------------------
  task automatic present(input logic [63:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = a;
    bus.req_write_i = w;
    bus.req_wdata_i = d;
    bus.req_wstrb_i = s;
  endtask

  task automatic complete(input int bp);
    bus.rsp_ready_i = 1'b0;
    repeat (bp) begin @(posedge clk_i); #1; end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    exp_valid = 1'b0; exp_ready = 1'b1; in_resp = 0;
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic accept_edge(input logic [63:0] a, input logic w,
                             input logic [31:0] d, input logic [3:0] s);
    @(posedge clk_i); #1;
    model_exec(a, w, d, s, exp_rdata, exp_error);
    update_irq();
    exp_valid = 1'b1; exp_ready = 1'b0; in_resp = 1;
  endtask

  // The new request is presented while the previous response is still
  // outstanding, so it must wait for the handshake before being accepted.
  task automatic access(input logic [63:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] s, input int bp);
    present(a, w, d, s);
    if (in_resp) complete(bp);
    accept_edge(a, w, d, s);
  endtask

  task automatic go_idle(input int bp);
    bus.req_valid_i = 1'b0;
    if (in_resp) complete(bp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] err_addr [4];
    logic        err_wr   [4];
    logic [31:0] saved;

    rst_i = 1'b1;
    bus.req_valid_i = 1'b0; bus.req_addr_i = '0; bus.req_write_i = 1'b0;
    bus.req_wdata_i = '0;   bus.req_wstrb_i = '0; bus.rsp_ready_i = 1'b0;
    model_reset();
    @(posedge clk_i); #1;
    chk_en = 1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Post-reset doorbell read
    access(BASE + 64'h08, 1'b0, 32'h0, 4'h0, 0);
    @(negedge clk_i);
    check("lit_reset_valid", 64'(bus.rsp_valid_o), 64'd1);
    check("lit_reset_rdata", 64'(bus.rsp_rdata_o), 64'd0);
    check("lit_reset_error", 64'(bus.rsp_error_o), 64'd0);
    check("lit_reset_irq", 64'({irq_rcv, irq_snd}), 64'd0);

    // Doorbell / ack / clear flow on mailbox 0
    access(BASE + 64'h14, 1'b1, 32'h3, 4'hF, 1);
    access(BASE + 64'h08, 1'b1, 32'h1, 4'hF, 0);
    @(negedge clk_i);
    check("lit_db_irq_rcv", 64'(irq_rcv[0]), 64'd1);
    access(BASE + 64'h0C, 1'b1, 32'h1, 4'hF, 0);
    @(negedge clk_i);
    check("lit_ack_irq_rcv", 64'(irq_rcv[0]), 64'd0);
    check("lit_ack_irq_snd", 64'(irq_snd[0]), 64'd1);
    access(BASE + 64'h10, 1'b1, 32'h1, 4'hF, 2);
    @(negedge clk_i);
    check("lit_clr_irq_snd", 64'(irq_snd[0]), 64'd0);

    // Byte-strobed letter on mailbox 3
    access(BASE + 64'hC4, 1'b1, 32'hDEAD_BEEF, 4'b0101, 2);
    access(BASE + 64'hC4, 1'b0, 32'h0, 4'h0, 0);
    @(negedge clk_i);
    check("lit_strobe_rdata", 64'(bus.rsp_rdata_o), 64'h00AD_00EF);
    check("lit_strobe_model", 64'(exp_rdata), 64'h00AD_00EF);
    access(BASE, 1'b1, 32'h1234_5678, 4'hF, 0);

    // Error accesses leave state untouched
    err_addr = '{BASE + 64'h100, BASE + 64'h2, BASE + 64'h1000, BASE + 64'h18};
    err_wr   = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      access(err_addr[i], err_wr[i], 32'hFFFF_FFFF, 4'hF, i);
      @(negedge clk_i);
      check("lit_err_error", 64'(bus.rsp_error_o), 64'd1);
      check("lit_err_rdata", 64'(bus.rsp_rdata_o), 64'd0);
    end
    access(BASE, 1'b0, 32'h0, 4'h0, 1);
    @(negedge clk_i);
    check("lit_after_err", 64'(bus.rsp_rdata_o), 64'h1234_5678);

    // Backpressure: 5 cycles with a competing request held valid
    present(BASE + 64'h04, 1'b0, 32'h0, 4'h0);
    bus.rsp_ready_i = 1'b0;
    saved = exp_rdata;
    repeat (5) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("bp_valid", 64'(bus.rsp_valid_o), 64'd1);
      check("bp_ready", 64'(bus.req_ready_o), 64'd0);
      check("bp_rdata", 64'(bus.rsp_rdata_o), 64'(saved));
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    exp_valid = 1'b0; exp_ready = 1'b1; in_resp = 0;
    bus.rsp_ready_i = 1'b0;
    @(negedge clk_i);
    check("bp_idle_ready", 64'(bus.req_ready_o), 64'd1);
    accept_edge(BASE + 64'h04, 1'b0, 32'h0, 4'h0);
    @(negedge clk_i);
    check("bp_accepted", 64'(bus.rsp_valid_o), 64'd1);

    // Ack with nothing pending on mailbox 1
    access(BASE + 64'h4C, 1'b1, 32'h1, 4'hF, 0);
    @(negedge clk_i);
    check("lit_ack_nop_err", 64'(bus.rsp_error_o), 64'd0);
    access(BASE + 64'h48, 1'b0, 32'h0, 4'h0, 0);
    @(negedge clk_i);
    check("lit_ack_nop_db", 64'(bus.rsp_rdata_o), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [63:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      int kind;
      kind = $urandom_range(0, 11);
      a = BASE + 64'($urandom_range(0, NUM - 1) * 64 + $urandom_range(0, 5) * 4);
      case (kind)
        0: a = BASE + 64'h1000 + 64'($urandom_range(0, 255) * 4);
        1: a = {$urandom(), $urandom()};
        2: a = a | 64'($urandom_range(1, 3));
        3: a = BASE + 64'($urandom_range(0, 15) * 64 + $urandom_range(6, 15) * 4);
        4: a = BASE + 64'($urandom_range(NUM, 15) * 64);
        default: ;
      endcase
      d = $urandom();
      if ($urandom_range(0, 2) != 0) d[0] = 1'b1;
      s = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      access(a, 1'($urandom_range(0, 1)), d, s, $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        go_idle($urandom_range(0, 2));
        repeat ($urandom_range(1, 3)) begin @(posedge clk_i); #1; end
      end
    end

    // Reset during RESP
    access(BASE + 64'h88, 1'b1, 32'h1, 4'hF, 0);
    bus.req_valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_reset();
    in_resp = 0;
    @(negedge clk_i);
    check("lit_rst_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("lit_rst_irq", 64'({irq_rcv, irq_snd}), 64'd0);
    for (int m = 0; m < NUM; m++) begin
      for (int r = 0; r < 6; r++) begin
        access(BASE + 64'(m * 64 + r * 4), 1'b0, 32'h0, 4'h0, $urandom_range(0, 1));
        @(negedge clk_i);
        check("lit_rst_rd", 64'(bus.rsp_rdata_o), 64'd0);
      end
    end
    go_idle(1);
    @(posedge clk_i); #1;
    @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
